// File: rtl/flags_pkg.sv
// Shared NZCV definitions: ALU op encodings, flag bit positions and the
// condition codes evaluated by the condition checker against these flags.
package flags_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // flag_w bit positions
  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Condition evaluation shared with the condition checker.
  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/flag_calc.sv
// Combinational NZCV generation from ALU operands and operation.
module flag_calc
  import flags_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_ctrl,
  output logic [3:0]       nzcv
);

  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  // Shared adder: SUB is a + ~b + 1, so carry-out means "no borrow".
  always_comb begin
    sub  = (alu_op_e'(alu_ctrl) == ALU_SUB);
    b_op = sub ? ~b : b;
    sum  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (alu_op_e'(alu_ctrl))
      ALU_ADD, ALU_SUB: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ res[WIDTH-1]);
      end
      ALU_AND: res = a & b;
      ALU_ORR: res = a | b;
      default: res = '0;
    endcase
    nzcv         = '0;
    nzcv[FLAG_N] = res[WIDTH-1];
    nzcv[FLAG_Z] = (res == '0);
    nzcv[FLAG_C] = c;
    nzcv[FLAG_V] = v;
  end

endmodule

// File: rtl/flag_register_unit.sv
// Architectural NZCV register with gated group writes, direct load and a
// same-cycle bypass of the value the register takes at the next edge.
module flag_register_unit
  import flags_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_ctrl,
  input  logic [1:0]       flag_w,
  input  logic             cond_ex,
  input  logic             stall,
  input  logic             flush,
  input  logic             load_en,
  input  logic [3:0]       load_value,
  output logic [3:0]       flags,
  output logic [3:0]       flags_next,
  output logic             flag_update
);

  logic [3:0] calc_nzcv;
  logic       we_nz;
  logic       we_cv;
  logic [3:0] flags_q, flags_d;
  logic       update_q, update_d;

  flag_calc #(
    .WIDTH (WIDTH)
  ) u_flag_calc (
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .nzcv     (calc_nzcv)
  );

  // Qualified per-group write enables for the instruction in execute.
  always_comb begin
    we_nz = flag_w[FW_NZ] & cond_ex & ~flush;
    we_cv = flag_w[FW_CV] & cond_ex & ~flush;
  end

  // Next-state priority: stall, then load, then ALU group writes, else hold.
  always_comb begin
    flags_d  = flags_q;
    update_d = update_q;
    if (stall) begin
      flags_d  = flags_q;
      update_d = update_q;
    end else if (load_en) begin
      flags_d  = load_value;
      update_d = 1'b1;
    end else begin
      if (we_nz) begin
        flags_d[FLAG_N] = calc_nzcv[FLAG_N];
        flags_d[FLAG_Z] = calc_nzcv[FLAG_Z];
      end
      if (we_cv) begin
        flags_d[FLAG_C] = calc_nzcv[FLAG_C];
        flags_d[FLAG_V] = calc_nzcv[FLAG_V];
      end
      update_d = we_nz | we_cv;
    end
  end

  // Flag register and update pulse; reset clears both asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q  <= '0;
      update_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      update_q <= update_d;
    end
  end

  assign flags       = flags_q;
  assign flags_next  = flags_d;
  assign flag_update = update_q;

endmodule
